// File: rtl/filter_ctrl_pkg.sv
// filter_ctrl_pkg: shared state, event and counter definitions for filter_event_ctrl.
package filter_ctrl_pkg;
    localparam int FEC_DROP_W = 8;
    localparam int FEC_DATA_W = 16;
    localparam int FEC_TS_W   = 32;
    typedef enum logic [1:0] {IDLE, ARMED, PEAK, DEAD} fec_state_t;
    typedef struct packed {
        logic [FEC_DATA_W-1:0] peak;
        logic [FEC_TS_W-1:0]   ts;
        logic                  pileup;
    } fec_event_t;
endpackage

// File: rtl/fec_event_fifo.sv
// fec_event_fifo: synchronous first-word-fall-through event buffer with full/empty flags.
module fec_event_fifo
    import filter_ctrl_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fec_event_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
    T mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic wr_en, rd_en;
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en = pop && !empty;
    // a full buffer still takes a push when the head leaves in the same cycle
    assign wr_en = push && (!full || rd_en);
    assign rdata = empty ? '0 : mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + ONE;
            if (rd_en) rd_q <= rd_q + ONE;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/filter_event_ctrl.sv
// filter_event_ctrl: threshold trigger, peak/timestamp capture, dead time and event buffering.
// Pile-up flagging during dead time is built only when FILTER_EVENT_PILEUP_EN is defined.
module filter_event_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int SIZE_FILTER_DATA = FEC_DATA_W,
    parameter int SIZE_TS          = FEC_TS_W,
    parameter int DEAD_TIME        = 16,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [SIZE_FILTER_DATA-1:0] filt_data,
    input  logic [SIZE_FILTER_DATA-1:0] threshold,
    output logic                        event_valid,
    input  logic                        event_ready,
    output logic [SIZE_FILTER_DATA-1:0] event_peak,
    output logic [SIZE_TS-1:0]          event_ts,
    output logic                        event_pileup,
    output logic                        busy,
    output logic [FEC_DROP_W-1:0]       drop_cnt
);
    typedef struct packed {
        logic [SIZE_FILTER_DATA-1:0] peak;
        logic [SIZE_TS-1:0]          ts;
        logic                        pileup;
    } event_t;
    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_TIME - 1);
    fec_state_t state_q, state_d;
    logic [SIZE_TS-1:0] ts_q, pts_q, pts_d;
    logic [SIZE_FILTER_DATA-1:0] peak_q, peak_d;
    logic [7:0] dead_q, dead_d;
    logic [FEC_DROP_W-1:0] drop_q, drop_d;
    logic push, pop, full, empty, pile;
    event_t ev_in, ev_out;

    always_comb begin
        state_d = state_q;
        peak_d  = peak_q;
        pts_d   = pts_q;
        dead_d  = dead_q;
        push    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            dead_d  = '0;
        end else begin
            case (state_q)
                IDLE:  state_d = ARMED;
                ARMED: if (filt_data > threshold) begin
                    state_d = PEAK;
                    peak_d  = filt_data;
                    pts_d   = ts_q;
                end
                PEAK: if (filt_data <= threshold) begin
                    state_d = DEAD;
                    push    = 1'b1;
                    dead_d  = DEAD_LOAD;
                end else if (filt_data > peak_q) begin
                    peak_d = filt_data;
                    pts_d  = ts_q;
                end
                DEAD: if (dead_q == 8'd0) state_d = ARMED;
                      else dead_d = dead_q - 8'd1;
            endcase
        end
    end

    assign pop    = event_ready && !empty;
    assign drop_d = (push && full && !pop && drop_q != '1) ? drop_q + 8'd1 : drop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ts_q    <= '0;
            pts_q   <= '0;
            peak_q  <= '0;
            dead_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + SIZE_TS'(1);
            pts_q   <= pts_d;
            peak_q  <= peak_d;
            dead_q  <= dead_d;
            drop_q  <= drop_d;
        end
    end

`ifdef FILTER_EVENT_PILEUP_EN
    logic pile_q, pile_d;
    assign pile_d = (!enable || state_q == IDLE || push) ? 1'b0 :
                    (state_q == DEAD && filt_data > threshold) ? 1'b1 : pile_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pile_q <= 1'b0;
        else pile_q <= pile_d;
    end
    assign pile = pile_q;
`else
    assign pile = 1'b0;
`endif

    assign ev_in = '{peak: peak_q, ts: pts_q, pileup: pile};

    fec_event_fifo #(.DEPTH(FIFO_DEPTH), .T(event_t)) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata(ev_in),
        .rdata(ev_out),
        .full (full),
        .empty(empty)
    );

    assign event_valid  = !empty;
    assign event_peak   = ev_out.peak;
    assign event_ts     = ev_out.ts;
    assign event_pileup = ev_out.pileup;
    assign busy         = (state_q == PEAK) || (state_q == DEAD);
    assign drop_cnt     = drop_q;
endmodule

// File: doc/filter_event_ctrl.md
FILTER_EVENT_CTRL -- requirements
Module: filter_event_ctrl

Interface
REQ-001 Parameter SIZE_FILTER_DATA, default 16, width of the shaped filter output being monitored.
REQ-002 Parameter SIZE_TS, default 32, width of the free-running timestamp.
REQ-003 Parameter DEAD_TIME, default 16, cycles held off after each event (range 1..255).
REQ-004 Parameter FIFO_DEPTH, default 4, event buffer depth (power of two, at least 2).
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  arm trigger; low forces IDLE.
REQ-008 filt_data  input  SIZE_FILTER_DATA  unsigned shaped filter output, one sample per clk.
REQ-009 threshold  input  SIZE_FILTER_DATA  unsigned trigger level; sampled every cycle.
REQ-010 event_valid  output  1  event word available.
REQ-011 event_ready  input  1  consumer accepts event when high with event_valid.
REQ-012 event_peak  output  SIZE_FILTER_DATA  maximum filt_data of the pulse.
REQ-013 event_ts  output  SIZE_TS  timestamp of the first sample equal to the peak.
REQ-014 event_pileup  output  1  re-trigger seen during dead time (see Configuration).
REQ-015 busy  output  1  high in PEAK and DEAD states.
REQ-016 drop_cnt  output  8  events lost to full FIFO, saturating at 255.

Function
REQ-017 ts counter increments every cycle out of reset and wraps from all-ones to 0.
REQ-018 States: IDLE, ARMED, PEAK, DEAD.
- IDLE->ARMED when enable=1.
- Any state->IDLE when enable=0, next cycle.
- An aborted pulse produces no event.
REQ-019 ARMED->PEAK when filt_data > threshold (strict).
- Captures peak=filt_data and ts=current count.
REQ-020 PEAK: when filt_data > stored peak (strict), peak and ts update. Equal values keep the earlier ts.
REQ-021 PEAK->DEAD when filt_data <= threshold.
- Pushes {peak, ts, pileup=0} to the FIFO in that same cycle.
- Loads the dead counter with DEAD_TIME-1.
REQ-022 DEAD decrements the counter each cycle. When the counter = 0, the state goes to ARMED on the next edge, so DEAD lasts exactly DEAD_TIME cycles.
REQ-023 Output event_valid rises the cycle after the push when the FIFO was empty.
REQ-024 Handshake:
- Transfer occurs when event_valid and event_ready are both high.
- event_peak, event_ts and event_pileup stay stable while event_valid=1 and event_ready=0.
- event_valid never drops without a transfer except on reset.
REQ-025 A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Otherwise the event is discarded and drop_cnt increments (saturating).
REQ-026 Pops are not blocked by enable=0. Buffered events remain deliverable in IDLE.
REQ-027 When empty, event_peak, event_ts and event_pileup output 0.

Reset
REQ-028 Asserting reset forces all of the following, mid-pulse included:
- state=IDLE, ts=0, dead counter=0, FIFO empty;
- event_valid=0, event_peak=0, event_ts=0, event_pileup=0, busy=0, drop_cnt=0.
REQ-029 Deassertion takes effect on the first clk edge afterwards; no event is generated from a pulse in progress at reset.

Configuration
REQ-030 Macro FILTER_EVENT_PILEUP_EN.
- Defined: if filt_data > threshold in any DEAD cycle, a sticky flag sets. The flag is written as event_pileup of the next pushed event and is cleared on that push or on IDLE.
- Undefined: no flag logic is built and event_pileup is constant 0.

Structure
REQ-031 Package filter_ctrl_pkg holds:
- the state enum typedef (fec_state_t);
- the event struct typedef (peak, ts, pileup);
- the drop counter width constant (8).
REQ-032 FIFO is the sub-module fec_event_fifo: synchronous, first-word-fall-through, parameterised by depth and the event struct, with full/empty flags.

Verification
REQ-033 Threshold=100, DEAD_TIME=16, pulse 50,120,300,250,90 -> one event: peak=300, ts=count at the 300 sample; event_valid 1 cycle after the 90 sample; busy high 1+2+16 cycles.
REQ-034 Plateau 200,200 then 80, threshold 100 -> event peak=200 with ts of the first 200 sample.
REQ-035 event_ready=0, FIFO_DEPTH=4, six well-separated pulses -> four events held stable; drop_cnt=2; each subsequent event_ready pulse pops one event in order.
REQ-036 enable dropped during PEAK -> IDLE next cycle, no event, drop_cnt unchanged; re-enable then a pulse -> a normal event.
REQ-037 reset asserted in DEAD with two events buffered -> event_valid=0 and drop_cnt=0 immediately; after release, first event ts counts from 0.
REQ-038 With FILTER_EVENT_PILEUP_EN defined, filt_data=150 in DEAD cycle 5 -> the next event has event_pileup=1 and the one after has event_pileup=0. Undefined -> always 0.
